// File: rtl/instr_fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned WORD_BYTES = 4;

  // An address is fetchable when it is word aligned and inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned words);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < words);
  endfunction

endpackage

// File: rtl/fetch_lat_counter.sv
// 4-bit memory settle counter with clear, increment and terminal flag.
module fetch_lat_counter
  import instr_fetch_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       term
);

  // Clear has priority over increment so a redirect always restarts the wait.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= 4'd0;
    end else if (inc) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign term = (cnt == 4'(MEM_LATENCY - 1));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction memory address, waits
// for the memory output to settle and hands instructions to decode.
//
//   state | meaning
//   WAIT  | mem_addr stable, counting memory settle cycles
//   HOLD  | if_valid high, waiting for decode to accept
//   FAULT | illegal address requested; fetching halted until legal redirect
module instr_fetch_ctrl
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned MEM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_inc, mem_addr_nxt;
  logic [3:0]   lat_cnt;
  logic         lat_term, lat_clr, lat_inc;
  logic         capture, handshake;

  fetch_lat_counter #(.MEM_LATENCY(MEM_LATENCY)) u_lat (
    .clk   (clk),
    .reset (reset),
    .clr   (lat_clr),
    .inc   (lat_inc),
    .cnt   (lat_cnt),
    .term  (lat_term)
  );

  assign pc_inc = pc + 32'(WORD_BYTES);

  // Next-state and datapath controls; redirect overrides everything except
  // that a simultaneous handshake still counts as a transfer.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    mem_addr_nxt = mem_addr;
    lat_clr      = 1'b0;
    lat_inc      = 1'b0;
    capture      = 1'b0;
    handshake    = (state == HOLD) && if_valid && if_ready;
    if (redirect_valid) begin
      if (addr_legal(redirect_pc, MEM_WORDS)) begin
        state_nxt    = WAIT;
        pc_nxt       = redirect_pc;
        mem_addr_nxt = redirect_pc;
        lat_clr      = 1'b1;
      end else begin
        state_nxt = FAULT;
      end
    end else begin
      case (state)
        WAIT: begin
          if (!addr_legal(pc, MEM_WORDS)) begin
            state_nxt = FAULT;
          end else if (lat_term) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else begin
            lat_inc = 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            pc_nxt = pc_inc;
            if (addr_legal(pc_inc, MEM_WORDS)) begin
              state_nxt    = WAIT;
              mem_addr_nxt = pc_inc;
              lat_clr      = 1'b1;
            end else begin
              state_nxt = FAULT;
            end
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = FAULT;
        end
      endcase
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT;
      pc          <= RESET_PC;
      mem_addr    <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 32'd0;
      fault       <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      mem_addr <= mem_addr_nxt;
      if_valid <= (state_nxt == HOLD);
      fault    <= (state_nxt == FAULT);
      if (capture) begin
        if_instr <= mem_instr;
        if_pc    <= pc;
      end
      if (handshake) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a combinational memory model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  instr_fetch_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .MEM_LATENCY (2),
    .MEM_WORDS   (1024)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_instr      (mem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Word 0/1 hold the test program; others are tagged with their index.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [9:0] idx;
    idx = addr[11:2];
    if (addr[31:12] != 20'd0) return 32'hDEAD_BEEF;
    if (idx == 10'd0) return 32'h2008_0005;
    if (idx == 10'd1) return 32'h2009_0003;
    return 32'hA000_0000 | {22'd0, idx};
  endfunction

  assign mem_instr = mem_word(mem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    step();
    step();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);

    // Reset release, streaming with if_ready high.
    reset = 1'b0;
    step();
    chk("first_wait", {31'd0, if_valid}, 32'd0);
    step();
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_instr", if_instr, 32'h2008_0005);
    step();
    chk("hs1_count", fetch_count, 32'd1);
    chk("hs1_valid", {31'd0, if_valid}, 32'd0);
    chk("hs1_addr", mem_addr, 32'h4);
    step();
    chk("w1_valid", {31'd0, if_valid}, 32'd0);
    step();
    chk("second_valid", {31'd0, if_valid}, 32'd1);
    chk("second_pc", if_pc, 32'h4);
    chk("second_instr", if_instr, 32'h2009_0003);
    step();
    chk("hs2_count", fetch_count, 32'd2);
    step();
    step();
    chk("third_pc", if_pc, 32'h8);

    // Decode stalls for 5 cycles in HOLD.
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_instr", if_instr, 32'hA000_0002);
      chk("stall_addr", mem_addr, 32'h8);
      chk("stall_count", fetch_count, 32'd2);
    end
    if_ready = 1'b1;
    step();
    chk("release_count", fetch_count, 32'd3);
    chk("release_addr", mem_addr, 32'hC);
    if_ready = 1'b0;
    step();
    step();
    chk("fourth_pc", if_pc, 32'hC);
    step();
    chk("one_transfer", fetch_count, 32'd3);

    // Redirect during the first WAIT cycle after a handshake.
    if_ready = 1'b1;
    step();
    chk("hs4_count", fetch_count, 32'd4);
    chk("hs4_addr", mem_addr, 32'h10);
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("rw_addr", mem_addr, 32'h40);
    chk("rw_valid0", {31'd0, if_valid}, 32'd0);
    step();
    chk("rw_valid1", {31'd0, if_valid}, 32'd0);
    step();
    chk("rw_valid2", {31'd0, if_valid}, 32'd1);
    chk("rw_pc", if_pc, 32'h40);
    chk("rw_instr", if_instr, 32'hA000_0010);
    chk("rw_count", fetch_count, 32'd4);

    // Redirect out of HOLD without a transfer, to reach if_pc 0x8.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    step();
    redirect_valid = 1'b0;
    chk("rh_count", fetch_count, 32'd4);
    chk("rh_valid", {31'd0, if_valid}, 32'd0);
    step();
    step();
    chk("rh_pc", if_pc, 32'h8);

    // Redirect coinciding with a handshake.
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    chk("rhs_count", fetch_count, 32'd5);
    chk("rhs_addr", mem_addr, 32'h80);
    chk("rhs_valid", {31'd0, if_valid}, 32'd0);
    step();
    step();
    chk("rhs_vld", {31'd0, if_valid}, 32'd1);
    chk("rhs_pc", if_pc, 32'h80);
    chk("rhs_instr", if_instr, 32'hA000_0020);

    // Illegal redirects fault; a legal one recovers.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_valid", {31'd0, if_valid}, 32'd0);
    chk("mis_addr", mem_addr, 32'h80);
    redirect_pc = 32'h1000;
    step();
    chk("oob_fault", {31'd0, fault}, 32'd1);
    chk("oob_valid", {31'd0, if_valid}, 32'd0);
    redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    chk("rec_fault", {31'd0, fault}, 32'd0);
    chk("rec_addr", mem_addr, 32'h8);
    step();
    step();
    chk("rec_valid", {31'd0, if_valid}, 32'd1);
    chk("rec_pc", if_pc, 32'h8);
    chk("rec_count", fetch_count, 32'd5);

    // Last word: accepting it must fault, not wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFC;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("last_pc", if_pc, 32'hFFC);
    chk("last_instr", if_instr, 32'hA000_03FF);
    if_ready = 1'b1;
    step();
    chk("end_count", fetch_count, 32'd6);
    chk("end_fault", {31'd0, fault}, 32'd1);
    chk("end_valid", {31'd0, if_valid}, 32'd0);
    chk("end_addr", mem_addr, 32'hFFC);
    step();
    chk("end_sticky", {31'd0, fault}, 32'd1);
    chk("end_nowrap", mem_addr, 32'hFFC);

    // Recover, then reset mid-WAIT on the edge that would capture.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    redirect_valid = 1'b0;
    chk("pre_addr", mem_addr, 32'h20);
    step();
    reset = 1'b1;
    step();
    chk("mid_valid", {31'd0, if_valid}, 32'd0);
    chk("mid_addr", mem_addr, 32'h0);
    chk("mid_fault", {31'd0, fault}, 32'd0);
    chk("mid_count", fetch_count, 32'd0);
    chk("mid_pc", if_pc, 32'h0);
    chk("mid_instr", if_instr, 32'h0);
    reset = 1'b0;
    step();
    step();
    chk("post_valid", {31'd0, if_valid}, 32'd1);
    chk("post_pc", if_pc, 32'h0);
    chk("post_instr", if_instr, 32'h2008_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
